multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Moore-style control FSM for the multicycle MIPS core.
- Sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 cycles per instruction, driven by the 6-bit opcode latched in the instruction register.
- Sits between the IR and the datapath muxes/enables; combines with the existing ALU decoder through `aluop`.
- Supported opcodes: RTYPE, LW, SW, BEQ, BNE, ADDI, ORI, J.

## Interface

- `clk`  in  1  — sole clock; all state changes on rising edge.
- `reset`  in  1  — synchronous, active-low; sampled on rising `clk`.
- `op`  in  6  — opcode from the IR (`instr[31:26]`).
- `mem_ready`  in  1  — memory access complete this cycle (used only with MC_MEMWAIT_EN).
- `mem_req`  out  1  — memory access requested (FETCH, MEMRD, MEMWR).
- `pcwrite`, `irwrite`, `regwrite`, `memwrite`  out  1 each  — write enables.
- `iord`, `alusrca`, `regdst`, `memtoreg`  out  1 each  — mux selects.
- `branch`, `bne`  out  1 each  — PC update conditional on zero / not-zero.
- `signOrZero`  out  1  — 1 selects zero-extended immediate.
- `alusrcb`  out  2  — selects 00 reg B, 01 const 4, 10 imm, 11 imm<<2.
- `pcsrc`  out  2  — selects 00 ALU result, 01 ALUOut, 10 jump target.
- `aluop`  out  2  — 00 add, 01 sub, 10 funct, 11 or.
- `illegal_op`  out  1  — one-cycle pulse on an unrecognised opcode.
- `retire`  out  1  — one-cycle pulse in the final cycle of each instruction.
- `state`  out  4  — current state encoding, for debug.

## Operation

- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 RTYPEEX, 7 ALUWB, 8 BEQEX, 9 ADDIEX, 10 IMMWB, 11 JEX, 12 ORIEX, 13 BNEEX
  - 14–15 unused; they return to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for LW or SW; RTYPEEX for RTYPE; BEQEX for BEQ; BNEEX for BNE; ADDIEX for ADDI; ORIEX for ORI; JEX for J.
  - DECODE→FETCH for any other opcode, with `illegal_op`=1.
  - MEMADR→MEMRD for LW, →MEMWR for SW.
  - MEMRD→MEMWB.
  - RTYPEEX→ALUWB.
  - ADDIEX and ORIEX→IMMWB.
  - MEMWB, MEMWR, ALUWB, IMMWB, BEQEX, BNEEX, JEX→FETCH.
- Outputs per state. Any output not listed is 0; no X is ever driven.
  - FETCH: `mem_req`, `irwrite`, `pcwrite`, `alusrcb`=01.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`, `alusrcb`=10.
  - MEMRD: `mem_req`, `iord`.
  - MEMWB: `regwrite`, `memtoreg`.
  - MEMWR: `mem_req`, `iord`, `memwrite`.
  - RTYPEEX: `alusrca`, `aluop`=10.
  - ALUWB: `regwrite`, `regdst`.
  - BEQEX: `alusrca`, `aluop`=01, `pcsrc`=01, `branch`.
  - BNEEX: same as BEQEX, but `bne` instead of `branch`.
  - ADDIEX: `alusrca`, `alusrcb`=10.
  - ORIEX: `alusrca`, `alusrcb`=10, `signOrZero`, `aluop`=11.
  - IMMWB: `regwrite`.
  - JEX: `pcwrite`, `pcsrc`=10.
- `retire` is asserted in the exit cycle of MEMWB, MEMWR, ALUWB, IMMWB, BEQEX, BNEEX and JEX. It is not asserted for an illegal opcode.
- `op` is sampled only in DECODE and MEMADR. The IR holds it stable from FETCH until the next FETCH.

## Timing

- Reset:
  - While `reset`=0: `pcwrite`, `irwrite`, `regwrite`, `memwrite`, `mem_req`, `illegal_op` and `retire` are forced to 0 combinationally.
  - At the first rising edge with `reset`=0: `state` becomes 0 (FETCH).
  - First fetch begins in the cycle after `reset` rises.
- Reset asserted mid-instruction (e.g. in MEMWR) aborts the instruction. No write enable is asserted during the reset cycle.
- Latency without wait states, counted from FETCH:
  - LW 5 cycles.
  - SW, RTYPE, ADDI, ORI 4 cycles.
  - BEQ, BNE, J 3 cycles.
  - Illegal opcode 2 cycles; PC is already incremented.
- Wait states are defined under Configuration.

## Configuration

- `MC_MEMWAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - `mem_req`, `iord` and `memwrite` stay high throughout the hold.
  - `irwrite` and `pcwrite` in FETCH are gated by `mem_ready`.
  - Each state advances on the edge where `mem_ready`=1. Each wait cycle adds one cycle of latency.
- `MC_MEMWAIT_EN` undefined:
  - `mem_ready` is ignored and every memory state lasts exactly one cycle.
  - `mem_req` is still driven.

## Test plan

- Reset low 2 cycles, then high, `op`=100011 (LW) → `state` sequence 0,1,2,3,4,0; `regwrite`=`memtoreg`=1 and `retire`=1 only in state 4.
- `op`=000101 (BNE) → states 0,1,13,0; in 13: `bne`=1, `branch`=0, `aluop`=01, `pcsrc`=01.
- `op`=001101 (ORI) → states 0,1,12,10,0; `signOrZero`=1 and `aluop`=11 in 12; `regwrite`=1, `regdst`=0 in 10.
- `op`=111111 → states 0,1,0; `illegal_op`=1 for exactly one cycle; `retire` stays 0.
- With `MC_MEMWAIT_EN`, SW with `mem_ready` low 3 cycles in MEMWR → `memwrite`=1 for 4 cycles; exit to FETCH on the 4th.
- `reset` pulled low while in MEMWR → `memwrite`=0 that cycle; `state`=0 next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS core.
// Optional memory wait states: define MC_MEMWAIT_EN.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic       branch,
    output logic       bne,
    output logic       signOrZero,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_ORIEX   = 4'd12;
    localparam logic [3:0] S_BNEEX   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_ok;
    logic       op_known;

`ifdef MC_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    // Memory always completes in one cycle; the handshake is ignored.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    assign state = state_q;

    // Opcode recognition, shared by next-state and illegal_op.
    always_comb begin
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_BNE, OP_ADDI, OP_ORI, OP_J: op_known = 1'b1;
            default:                       op_known = 1'b0;
        endcase
    end

    // Next-state logic; memory states hold until mem_ok.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state; reset masks every side effect.
    always_comb begin
        mem_req    = 1'b0;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        signOrZero = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                irwrite = mem_ok;
                pcwrite = mem_ok;
                alusrcb = 2'b01;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~op_known;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_ok;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = (state_q == S_BEQEX);
                bne     = (state_q == S_BNEEX);
                retire  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                signOrZero = 1'b1;
                aluop      = 2'b11;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                retire  = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req    = 1'b0;
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            illegal_op = 1'b0;
            retire     = 1'b0;
        end
    end

    // State register with synchronous active-low reset to FETCH.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Expected per-cycle states/controls are queued, then drained.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, pcwrite, irwrite, regwrite, memwrite;
    logic       iord, alusrca, regdst, memtoreg, branch, bne;
    logic       signOrZero, illegal_op, retire;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MC_MEMWAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  st;
        logic [19:0] vec;
        logic        rdy;
        logic        rst;
        string       tag;
    } step_t;

    step_t sb_q[$];
    logic [5:0] cur_op;
    logic [19:0] dut_vec;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .pcwrite(pcwrite), .irwrite(irwrite),
        .regwrite(regwrite), .memwrite(memwrite), .iord(iord),
        .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .branch(branch), .bne(bne), .signOrZero(signOrZero),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal_op(illegal_op), .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {mem_req, pcwrite, irwrite, regwrite, memwrite,
                      iord, alusrca, regdst, memtoreg, branch, bne,
                      signOrZero, alusrcb, pcsrc, aluop,
                      illegal_op, retire};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic known(input logic [5:0] o);
        case (o)
            6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000101, 6'b001000, 6'b001101, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Control word expected for a state, straight from the state table.
    function automatic logic [19:0] exp_vec(input logic [3:0] s,
                                            input logic [5:0] o,
                                            input logic rst,
                                            input logic rdy);
        logic mr, pw, iw, rw, mw, io, sa, rd, mt, br, bn, sz, il, rt;
        logic [1:0] sb, ps, ao;
        logic ok;
        ok = WAIT_EN ? rdy : 1'b1;
        {mr, pw, iw, rw, mw, io, sa, rd, mt, br, bn, sz, il, rt} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            4'd0:  begin mr = 1; iw = ok; pw = ok; sb = 2'b01; end
            4'd1:  begin sb = 2'b11; il = ~known(o); end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; mt = 1; rt = 1; end
            4'd5:  begin mr = 1; io = 1; mw = 1; rt = ok; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; rt = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; rt = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: begin rw = 1; rt = 1; end
            4'd11: begin pw = 1; ps = 2'b10; rt = 1; end
            4'd12: begin sa = 1; sb = 2'b10; sz = 1; ao = 2'b11; end
            4'd13: begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; rt = 1; end
            default: ;
        endcase
        if (!rst) {pw, iw, rw, mw, mr, il, rt} = '0;
        return {mr, pw, iw, rw, mw, io, sa, rd, mt, br, bn, sz,
                sb, ps, ao, il, rt};
    endfunction

    task automatic push(input string tag, input logic [3:0] st,
                        input logic rdy = 1'b1, input logic rst = 1'b1);
        step_t e;
        e.st  = st;
        e.rdy = rdy;
        e.rst = rst;
        e.tag = tag;
        e.vec = exp_vec(st, cur_op, rst, rdy);
        sb_q.push_back(e);
    endtask

    // Drives one cycle per entry, compares at the falling edge.
    task automatic drain();
        step_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            reset = e.rst;
            mem_ready = e.rdy;
            op = cur_op;
            @(negedge clk);
            check({e.tag, ".st"}, 32'(state), 32'(e.st));
            check({e.tag, ".ctl"}, 32'(dut_vec), 32'(e.vec));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag, input logic [5:0] o,
                       input logic [3:0] s2, input logic [3:0] s3,
                       input logic [3:0] s4, input int n);
        logic [3:0] seq [5];
        cur_op = o;
        seq[0] = 4'd0; seq[1] = 4'd1;
        seq[2] = s2; seq[3] = s3; seq[4] = s4;
        for (int i = 0; i < n; i++) push(tag, seq[i]);
        drain();
    endtask

    initial begin
        reset = 1'b0;
        op = 6'd0;
        mem_ready = 1'b1;
        cur_op = 6'd0;
        @(negedge clk);
        check("rst.en", 32'({pcwrite, irwrite, regwrite, memwrite,
                             mem_req, illegal_op, retire}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(state), 32'd0);

        run("LW",   6'b100011, 4'd2,  4'd3,  4'd4, 5);
        run("BNE",  6'b000101, 4'd13, 4'd0,  4'd0, 3);
        run("ORI",  6'b001101, 4'd12, 4'd10, 4'd0, 4);
        run("ILL",  6'b111111, 4'd0,  4'd0,  4'd0, 2);
        run("RTY",  6'b000000, 4'd6,  4'd7,  4'd0, 4);
        run("ADDI", 6'b001000, 4'd9,  4'd10, 4'd0, 4);
        run("SW",   6'b101011, 4'd2,  4'd5,  4'd0, 4);
        run("BEQ",  6'b000100, 4'd8,  4'd0,  4'd0, 3);
        run("J",    6'b000010, 4'd11, 4'd0,  4'd0, 3);

        if (WAIT_EN) begin
            cur_op = 6'b101011;
            push("WSW", 4'd0, 1'b0);
            push("WSW", 4'd0, 1'b1);
            push("WSW", 4'd1);
            push("WSW", 4'd2);
            for (int i = 0; i < 3; i++) push("WSW", 4'd5, 1'b0);
            push("WSW", 4'd5, 1'b1);
            drain();
        end

        cur_op = 6'b101011;
        push("RSW", 4'd0);
        push("RSW", 4'd1);
        push("RSW", 4'd2);
        push("RSW", 4'd5, 1'b1, 1'b0);
        push("RSW", 4'd0, 1'b1, 1'b0);
        drain();
        run("J2", 6'b000010, 4'd11, 4'd0, 4'd0, 3);
        run("LW2", 6'b100011, 4'd2, 4'd3, 4'd4, 5);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
